// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table and segment bit positions.
// Used by both the display driver and the scan decoder.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A_HEX = 7'b1110111;
  localparam logic [6:0] SEG_B_HEX = 7'b0011111;
  localparam logic [6:0] SEG_C_HEX = 7'b1001110;
  localparam logic [6:0] SEG_D_HEX = 7'b0111101;
  localparam logic [6:0] SEG_E_HEX = 7'b1001111;
  localparam logic [6:0] SEG_F_HEX = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern to hex value decoder.
// Flags recognised patterns (hit) and the all-off pattern (blank).
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] value
);

  // Table lookup; anything unlisted is neither hit nor blank.
  always_comb begin
    hit   = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A_HEX: value = 4'hA;
      SEG_B_HEX: value = 4'hB;
      SEG_C_HEX: value = 4'hC;
      SEG_D_HEX: value = 4'hD;
      SEG_E_HEX: value = 4'hE;
      SEG_F_HEX: value = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment scan.
// A {an,seg} pair must be stable STABLE_CYCLES samples to commit.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic                  upd,
  output logic [2:0]            upd_idx
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic [CW-1:0]     cnt;
  logic              onehot;
  logic              same;
  logic              commit;
  logic [2:0]        idx;
  logic              hit;
  logic              blank;
  logic [3:0]        value;

  seg7_pattern_decode u_dec (
    .seg   (seg),
    .hit   (hit),
    .blank (blank),
    .value (value)
  );

  assign onehot = $onehot(an);
  assign same   = (an == an_q) && (seg == seg_q);
  // Fires only on the edge the count reaches STABLE_CYCLES.
  assign commit = onehot && same &&
                  (cnt == CW'(STABLE_CYCLES - 1));

  // One-hot digit select to binary index.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an[i]) idx = 3'(i);
    end
  end

  // Sample register and saturating stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= '0;
      cnt   <= '0;
    end else begin
      an_q  <= an;
      seg_q <= seg;
      if (!onehot) begin
        cnt <= '0;
      end else if (!same) begin
        cnt <= CW'(1);
      end else if (cnt != CW'(STABLE_CYCLES)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Per-digit result registers and commit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits  <= '0;
      valid   <= '0;
      err     <= '0;
      upd     <= 1'b0;
      upd_idx <= 3'd0;
    end else begin
      upd <= commit;
      if (commit) upd_idx <= idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (commit && an[i]) begin
          if (hit) begin
            digits[4*i +: 4] <= value;
            valid[i]         <= 1'b1;
            err[i]           <= 1'b0;
          end else begin
            valid[i] <= 1'b0;
            err[i]   <= !blank;
          end
        end
      end
    end
  end

endmodule
